// File: rtl/duram_fifo_ctrl.sv
// duram_fifo_ctrl: single-clock FIFO controller for an external dual-port RAM.
// Port A writes at wr_ptr, port B reads combinationally at rd_ptr.
module duram_fifo_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int AFULL_LEVEL  = 28,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_wren_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc, rd_acc;

    // Status flags come from the count register alone.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

    assign wr_acc = wr_en & ~full & ~clear;
    assign rd_acc = rd_en & ~empty & ~clear;

    assign ram_data_a = wr_data;
    assign ram_wren_a = wr_acc;
    assign ram_addr_a = wr_ptr_q;
    assign ram_addr_b = rd_ptr_q;

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Next-state for pointers, occupancy, read register and sticky errors.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        ovf_d      = ovf_q | (wr_en & full);
        unf_d      = unf_q | (rd_en & empty);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            rd_data_d = ram_q_b;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end
    end

    // State registers; Reset additionally zeroes the read data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

endmodule

// File: tb/tb_duram_fifo_ctrl.sv
// Testbench for duram_fifo_ctrl with a behavioural dual-port RAM beside it
// and a queue-based FIFO reference model.
module tb_duram_fifo_ctrl;

    logic        Clk;
    logic        Reset;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [5:0]  count;
    logic        full, empty, almost_full, almost_empty;
    logic        overflow, underflow;
    logic [31:0] ram_data_a;
    logic        ram_wren_a;
    logic [4:0]  ram_addr_a, ram_addr_b;
    logic [31:0] ram_q_b;

    int checks = 0;
    int errors = 0;

    duram_fifo_ctrl dut (
        .Clk(Clk), .Reset(Reset), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow),
        .ram_data_a(ram_data_a), .ram_wren_a(ram_wren_a),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_q_b(ram_q_b)
    );

    // RAM: synchronous write on port A, combinational read on port B.
    logic [31:0] mem [32];
    always @(posedge Clk) if (ram_wren_a) mem[ram_addr_a] <= ram_data_a;
    assign ram_q_b = mem[ram_addr_b];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model.
    logic [31:0] mq[$];
    logic        m_ovf, m_unf, m_rv;
    logic [31:0] m_rd;
    logic [4:0]  m_wa, m_ra;

    logic [32:0] obs_pre, exp_pre;
    logic [64:0] obs;
    assign obs = {ram_addr_a, ram_addr_b, count, full, empty,
                  almost_full, almost_empty, overflow, underflow,
                  rd_valid, rd_data};

    function automatic logic [64:0] expv();
        int n = mq.size();
        return {m_wa, m_ra, 6'(n), n == 32, n == 0, n >= 28, n <= 4,
                m_ovf, m_unf, m_rv, m_rd};
    endfunction

    function automatic void model_reset(input logic hard);
        mq.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0;
        m_wa = '0; m_ra = '0;
        if (hard) m_rd = '0;
    endfunction

    task automatic step(input logic w, input logic r, input logic c,
                        input logic [31:0] d);
        logic wacc, racc;
        int n;
        wr_en = w; rd_en = r; clear = c; wr_data = d;
        #1;
        obs_pre = {ram_wren_a, ram_data_a};
        n = mq.size();
        wacc = w & !c & (n != 32);
        racc = r & !c & (n != 0);
        exp_pre = {wacc, d};
        if (c) begin
            model_reset(1'b0);
        end else begin
            if (w && n == 32) m_ovf = 1'b1;
            if (r && n == 0)  m_unf = 1'b1;
            m_rv = racc;
            if (racc) begin
                m_rd = mq.pop_front();
                m_ra = m_ra + 5'd1;
            end
            if (wacc) begin
                mq.push_back(d);
                m_wa = m_wa + 5'd1;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; wr_en = 0; rd_en = 0; clear = 0; wr_data = '0;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
        model_reset(1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        if (obs !== expv()) begin
            errors++;
            $display("FAIL reset got=%h want=%h", obs, expv());
        end
        checks++;
    endtask

    task automatic test_fill();
        bit seen_af = 0;
        for (int i = 1; i <= 32; i++) begin
            step(1, 0, 0, 32'(i));
            if (obs_pre !== exp_pre) begin
                errors++;
                $display("FAIL fill_wr[%0d] got=%h want=%h", i, obs_pre, exp_pre);
            end
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL fill[%0d] got=%h want=%h", i, obs, expv());
            end
            checks++;
            if (almost_full && !seen_af) begin
                seen_af = 1;
                if (count !== 6'd28) begin
                    errors++;
                    $display("FAIL afull_first got=%0d want=28", count);
                end
                checks++;
            end
        end
        if (full !== 1'b1 || count !== 6'd32 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_end got=%b/%0d/%b want=1/32/0", full, count, overflow);
        end
        checks++;
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 32'hDEADBEEF);
        if (obs_pre[32] !== 1'b0 || obs !== expv()) begin
            errors++;
            $display("FAIL ovf got=%h/%h want=0/%h", obs_pre[32], obs, expv());
        end
        checks++;
        for (int i = 1; i <= 32; i++) begin
            step(0, 1, 0, '0);
            if (obs !== expv() || rd_data !== 32'(i)) begin
                errors++;
                $display("FAIL drain[%0d] got=%h want=%h", i, obs, expv());
            end
            checks++;
        end
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_end got=%b/%b want=1/1", empty, overflow);
        end
        checks++;
    endtask

    task automatic test_underflow();
        step(0, 1, 0, '0);
        if (obs !== expv() || underflow !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL unf got=%h want=%h", obs, expv());
        end
        checks++;
        step(1, 1, 0, 32'hCAFE0001);
        if (obs_pre !== exp_pre || obs !== expv() || count !== 6'd1) begin
            errors++;
            $display("FAIL unf_both got=%h want=%h", obs, expv());
        end
        checks++;
        step(0, 1, 0, '0);
        if (obs !== expv() || rd_data !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL unf_pop got=%h want=%h", obs, expv());
        end
        checks++;
    endtask

    task automatic test_wrap();
        int plan[4] = '{20, 20, 30, 30};
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < plan[p]; i++) begin
                step(p[0] == 0, p[0] == 1, 0, $urandom);
                if (obs_pre !== exp_pre || obs !== expv()) begin
                    errors++;
                    $display("FAIL wrap[%0d.%0d] got=%h want=%h", p, i, obs, expv());
                end
                checks++;
            end
        end
        if (count !== 6'd0) begin
            errors++;
            $display("FAIL wrap_end got=%0d want=0", count);
        end
        checks++;
    endtask

    task automatic test_full_both();
        logic [31:0] oldest;
        for (int i = 0; i < 32; i++) step(1, 0, 0, $urandom);
        oldest = mq[0];
        step(1, 1, 0, 32'h12345678);
        if (obs_pre[32] !== 1'b0 || obs !== expv() || count !== 6'd31
            || rd_data !== oldest || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_both got=%h want=%h", obs, expv());
        end
        checks++;
    endtask

    task automatic test_clear();
        step(0, 0, 1, '0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, $urandom);
        step(0, 1, 0, '0);
        step(1, 0, 0, $urandom);
        step(1, 1, 1, 32'hBAD0BAD0);
        if (obs_pre !== exp_pre || obs !== expv() || count !== 6'd0
            || rd_valid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL clear got=%h/%h want=%h/%h", obs_pre, obs, exp_pre, expv());
        end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 2, $urandom);
            if (obs_pre !== exp_pre || obs !== expv()) begin
                errors++;
                $display("FAIL rand[%0d] got=%h/%h want=%h/%h",
                         i, obs_pre, obs, exp_pre, expv());
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'hA0 + 32'(i));
        step(0, 1, 0, '0);
        wr_en = 1; rd_en = 1; clear = 0; wr_data = 32'h55; Reset = 1;
        @(posedge Clk); #1;
        Reset = 0;
        model_reset(1'b1);
        if (obs !== expv() || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got=%h want=%h", obs, expv());
        end
        checks++;
        step(0, 0, 0, '0);
        if (obs !== expv()) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", obs, expv());
        end
        checks++;
    endtask

    initial begin
        Reset = 1; clear = 0; wr_en = 0; rd_en = 0; wr_data = '0;
        model_reset(1'b1);
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_wrap();
        test_full_both();
        test_clear();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
